iob_cache_replace_ctrl: RTL and testbench
=========================================

Name: iob_cache_replace_ctrl

Overview:
Sequencer for the cache replacement-policy block and the valid/tag array. It accepts lookup results one at a time.
- Hit: issues the policy update.
- Miss: picks a victim (lowest invalid way first, otherwise the policy's way select), runs the line-fill handshake, then commits the policy update.
- Flush: sweeps the valid memory and clears the policy state.
It sits between the cache front-end and back-end and drives the replacement block's write enable, line address, way-hit and reset inputs.

Parameters:
N_WAYS, 8, associativity; power of two, >=2
NWAYS_W, $clog2(N_WAYS), way index width
NLINES_W, 7, line (set) address width; >=1

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, synchronous, active-low
req_valid_i  in  1  lookup result valid
req_ready_o  out  1  controller can accept a lookup
req_line_i  in  NLINES_W  set index of the lookup
req_hit_i  in  1  1=hit, 0=miss
req_way_hit_i  in  N_WAYS  one-hot hit way; ignored on miss
req_valid_ways_i  in  N_WAYS  valid bits of the set at lookup
flush_i  in  1  invalidate-all request (level, latched)
rep_we_o  out  1  replacement-memory write enable
rep_line_o  out  NLINES_W  replacement-memory line address
rep_way_hit_o  out  N_WAYS  way-hit vector presented to the replacement block
rep_way_select_i  in  N_WAYS  replacement block's one-hot victim for rep_line_o
rep_rst_o  out  1  clears the replacement memory (active-high, 1 cycle)
fill_req_o  out  1  line-fill request to back-end
fill_line_o  out  NLINES_W  line being filled
fill_way_o  out  N_WAYS  one-hot victim way being filled
fill_ack_i  in  1  fill complete
vld_clr_we_o  out  1  clear valid bits of vld_clr_line_o (all ways)
vld_clr_line_o  out  NLINES_W  flush sweep line
done_o  out  1  1-cycle pulse: request finished
done_way_o  out  N_WAYS  way used by the finished request (hit way or victim)
busy_o  out  1  state != IDLE or flush pending

Behaviour:
- Reset (rst_n_i=0 at a clk_i edge):
  - state=IDLE, flush_pend=0, all registered outputs 0, req_ready_o=1.
  - Reset mid-fill abandons the fill; fill_req_o=0 the next cycle.
- FSM states: IDLE, UPD, VICTIM, FILL, FLUSH, FLUSH_END.
- req_ready_o=1 only in IDLE with flush_pend=0 and flush_i=0. A lookup is accepted on req_valid_i & req_ready_o; line, hit and way vectors are latched.
- IDLE:
  - flush_i or flush_pend -> FLUSH; flush has priority over a simultaneous req_valid_i, which is not accepted.
  - Accepted hit -> UPD.
  - Accepted miss -> VICTIM.
- UPD (1 cycle):
  - rep_we_o=1, rep_line_o=latched line, rep_way_hit_o=latched way (hit way or victim).
  - done_o=1, done_way_o=the same way; -> IDLE.
  - A hit completes in 2 cycles; max throughput is 1 request per 2 cycles.
- VICTIM (1 cycle):
  - rep_line_o=latched line, rep_way_hit_o=0, rep_we_o=0.
  - If ~&req_valid_ways: victim = lowest-index zero bit.
  - Else: victim = rep_way_select_i; if that is zero or not one-hot, victim = lowest set bit, with 0 mapped to way 0.
  - -> FILL.
- FILL:
  - fill_req_o=1; fill_line_o and fill_way_o are held stable until the cycle fill_ack_i=1 is sampled.
  - fill_ack_i -> UPD with the way set to the victim; fill_req_o=0 in the next cycle.
  - fill_ack_i outside FILL is ignored.
- FLUSH:
  - Counter starts at 0. Each cycle: vld_clr_we_o=1, vld_clr_line_o=cnt, cnt+1.
  - At cnt=2^NLINES_W-1 -> FLUSH_END; the counter wraps to 0 and no carry bit is kept.
  - The sweep takes exactly 2^NLINES_W cycles.
- FLUSH_END: rep_rst_o=1 for 1 cycle, flush_pend cleared, -> IDLE.
- flush_i while in UPD/VICTIM/FILL: flush_pend set; the current operation completes first, then FLUSH.
- flush_i held through FLUSH_END re-arms exactly one further flush.
- rep_line_o outside UPD/VICTIM holds the last latched line. rep_way_hit_o=0 and rep_we_o=0 outside UPD.

Decomposition:
- iob_cache_pkg / iob_cache_conf.vh gets:
  - state encodings (3-bit localparams),
  - a lowest-set-bit priority-encoder function shared with the onehot_to_bin users.
- One sub-module: iob_cache_prio_onehot (N_WAYS in, one-hot lowest set bit out, zero-flag). It is instanced twice: invalid-way pick and select sanitising.

Test Plan:
1. Reset, then hit line 5, way_hit=8'h04 -> next cycle rep_we_o=1, rep_line_o=5, rep_way_hit_o=8'h04, done_o=1, done_way_o=8'h04; req_ready_o=1 the cycle after.
2. Miss line 3, valid_ways=8'hFB, rep_way_select_i=8'h80 -> fill_way_o=8'h04 (invalid way wins); fill_ack_i after 4 cycles -> rep_way_hit_o=8'h04 with rep_we_o=1 one cycle later.
3. Miss with valid_ways=8'hFF, rep_way_select_i=8'h10 -> fill_way_o=8'h10 held stable until ack; rep_way_select_i=8'h00 in a repeat -> fill_way_o=8'h01.
4. flush_i with NLINES_W=3 -> vld_clr_we_o high 8 cycles, lines 0..7 in order, then rep_rst_o one cycle, busy_o low afterwards.
5. flush_i asserted during FILL and req_valid_i asserted in the same cycle as return to IDLE -> fill completes, then flush runs, req not accepted until flush done.
6. rst_n_i low during FILL -> fill_req_o=0, req_ready_o=1, done_o=0 after the reset edge.

Source files
------------

// File: rtl/iob_cache_pkg.sv
// rtl/iob_cache_pkg.sv - shared types and helpers for the cache replacement sequencer
// Purpose: FSM state encodings and a lowest-set-bit priority encoder used by
//          the one-hot pickers and any onehot_to_bin style consumer.
// Ports:   none (package).
package iob_cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_UPD       = 3'd1,
    ST_VICTIM    = 3'd2,
    ST_FILL      = 3'd3,
    ST_FLUSH     = 3'd4,
    ST_FLUSH_END = 3'd5
  } state_t;

  // Widest way vector the encoder handles; callers zero-extend into it.
  localparam int MAX_WAYS = 64;

  // Index of the lowest set bit; 0 when the vector is empty (callers check
  // emptiness separately).
  function automatic int unsigned lowest_set_idx(input logic [MAX_WAYS-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/iob_cache_replace_ctrl_if.sv
// rtl/iob_cache_replace_ctrl_if.sv - lookup, fill, replacement and valid-clear signal bundle
// Purpose: groups every non-clock/reset signal of the replacement sequencer.
// Ports:   slave modport = controller side, master modport = surrounding cache.
//          req_*  lookup handshake, rep_* replacement-memory control,
//          fill_* line-fill handshake, vld_clr_* valid sweep, done/busy status.
interface iob_cache_replace_ctrl_if #(
  parameter int N_WAYS   = 8,
  parameter int NLINES_W = 7
);
  logic                req_valid_i;
  logic                req_ready_o;
  logic [NLINES_W-1:0] req_line_i;
  logic                req_hit_i;
  logic [N_WAYS-1:0]   req_way_hit_i;
  logic [N_WAYS-1:0]   req_valid_ways_i;
  logic                flush_i;
  logic                rep_we_o;
  logic [NLINES_W-1:0] rep_line_o;
  logic [N_WAYS-1:0]   rep_way_hit_o;
  logic [N_WAYS-1:0]   rep_way_select_i;
  logic                rep_rst_o;
  logic                fill_req_o;
  logic [NLINES_W-1:0] fill_line_o;
  logic [N_WAYS-1:0]   fill_way_o;
  logic                fill_ack_i;
  logic                vld_clr_we_o;
  logic [NLINES_W-1:0] vld_clr_line_o;
  logic                done_o;
  logic [N_WAYS-1:0]   done_way_o;
  logic                busy_o;

  modport slave (
    input  req_valid_i, req_line_i, req_hit_i, req_way_hit_i, req_valid_ways_i,
           flush_i, rep_way_select_i, fill_ack_i,
    output req_ready_o, rep_we_o, rep_line_o, rep_way_hit_o, rep_rst_o,
           fill_req_o, fill_line_o, fill_way_o, vld_clr_we_o, vld_clr_line_o,
           done_o, done_way_o, busy_o
  );

  modport master (
    output req_valid_i, req_line_i, req_hit_i, req_way_hit_i, req_valid_ways_i,
           flush_i, rep_way_select_i, fill_ack_i,
    input  req_ready_o, rep_we_o, rep_line_o, rep_way_hit_o, rep_rst_o,
           fill_req_o, fill_line_o, fill_way_o, vld_clr_we_o, vld_clr_line_o,
           done_o, done_way_o, busy_o
  );
endinterface

// File: rtl/iob_cache_prio_onehot.sv
// rtl/iob_cache_prio_onehot.sv - lowest-set-bit one-hot picker
// Purpose: reduces a way vector to the one-hot of its lowest set bit.
// Ports:   vec_i    input way vector
//          onehot_o one-hot lowest set bit (all zero when vec_i is zero)
//          zero_o   vec_i has no bit set
module iob_cache_prio_onehot
  import iob_cache_pkg::*;
#(
  parameter int N_WAYS = 8
) (
  input  logic [N_WAYS-1:0] vec_i,
  output logic [N_WAYS-1:0] onehot_o,
  output logic              zero_o
);

  int unsigned idx;

  assign idx      = lowest_set_idx(MAX_WAYS'(vec_i));
  assign zero_o   = ~|vec_i;
  assign onehot_o = zero_o ? '0 : (N_WAYS'(1) << idx);

endmodule

// File: rtl/iob_cache_replace_ctrl.sv
// rtl/iob_cache_replace_ctrl.sv - replacement-policy and valid-array sequencer
// Purpose: takes lookup results one at a time; hits update the policy, misses
//          pick a victim, run the line fill and then update the policy, and
//          flushes sweep the valid array and clear the policy state.
// Ports:   clk_i   clock
//          rst_n_i synchronous active-low reset
//          bus     iob_cache_replace_ctrl_if.slave (lookup, fill, replacement,
//                  valid-clear and status signals)
module iob_cache_replace_ctrl
  import iob_cache_pkg::*;
#(
  parameter int N_WAYS   = 8,
  parameter int NLINES_W = 7
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  iob_cache_replace_ctrl_if.slave     bus
);

  state_t              state, state_nx;
  logic                flush_pend, flush_pend_nx;
  logic [NLINES_W-1:0] cnt, cnt_nx;
  logic [NLINES_W-1:0] line_q;
  logic [N_WAYS-1:0]   way_q;
  logic [N_WAYS-1:0]   vways_q;
  logic                accept;

  logic [N_WAYS-1:0]   inv_low, sel_low, victim;
  logic                inv_zero, sel_zero;

  // Lowest invalid way of the latched set.
  iob_cache_prio_onehot #(.N_WAYS(N_WAYS)) u_inv_pick (
    .vec_i    (~vways_q),
    .onehot_o (inv_low),
    .zero_o   (inv_zero)
  );

  // Sanitised policy choice: a one-hot select passes through unchanged, a
  // multi-hot select collapses to its lowest bit.
  iob_cache_prio_onehot #(.N_WAYS(N_WAYS)) u_sel_pick (
    .vec_i    (bus.rep_way_select_i),
    .onehot_o (sel_low),
    .zero_o   (sel_zero)
  );

  assign victim = !inv_zero ? inv_low : (sel_zero ? N_WAYS'(1) : sel_low);

  assign bus.req_ready_o = (state == ST_IDLE) && !flush_pend && !bus.flush_i;
  assign accept          = bus.req_valid_i && bus.req_ready_o;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= ST_IDLE;
      flush_pend <= 1'b0;
      cnt        <= '0;
      line_q     <= '0;
      way_q      <= '0;
      vways_q    <= '0;
    end else begin
      state      <= state_nx;
      flush_pend <= flush_pend_nx;
      cnt        <= cnt_nx;
      if (accept) begin
        line_q  <= bus.req_line_i;
        way_q   <= bus.req_way_hit_i;
        vways_q <= bus.req_valid_ways_i;
      end
      // On a miss the latched hit vector is meaningless; replace it with the victim.
      if (state == ST_VICTIM) way_q <= victim;
    end
  end

  always_comb begin
    state_nx      = state;
    flush_pend_nx = flush_pend;
    cnt_nx        = cnt;
    unique case (state)
      ST_IDLE: begin
        if (bus.flush_i || flush_pend) begin
          state_nx      = ST_FLUSH;
          flush_pend_nx = 1'b0;
          cnt_nx        = '0;
        end else if (accept) begin
          state_nx = bus.req_hit_i ? ST_UPD : ST_VICTIM;
        end
      end
      ST_UPD: begin
        flush_pend_nx = flush_pend || bus.flush_i;
        state_nx      = ST_IDLE;
      end
      ST_VICTIM: begin
        flush_pend_nx = flush_pend || bus.flush_i;
        state_nx      = ST_FILL;
      end
      ST_FILL: begin
        flush_pend_nx = flush_pend || bus.flush_i;
        if (bus.fill_ack_i) state_nx = ST_UPD;
      end
      ST_FLUSH: begin
        cnt_nx = cnt + NLINES_W'(1);
        if (&cnt) state_nx = ST_FLUSH_END;
      end
      ST_FLUSH_END: begin
        // A flush request still held here queues exactly one more sweep.
        flush_pend_nx = bus.flush_i;
        state_nx      = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign bus.rep_we_o       = (state == ST_UPD);
  assign bus.rep_line_o     = line_q;
  assign bus.rep_way_hit_o  = (state == ST_UPD) ? way_q : '0;
  assign bus.rep_rst_o      = (state == ST_FLUSH_END);
  assign bus.fill_req_o     = (state == ST_FILL);
  assign bus.fill_line_o    = line_q;
  assign bus.fill_way_o     = way_q;
  assign bus.vld_clr_we_o   = (state == ST_FLUSH);
  assign bus.vld_clr_line_o = cnt;
  assign bus.done_o         = (state == ST_UPD);
  assign bus.done_way_o     = (state == ST_UPD) ? way_q : '0;
  assign bus.busy_o         = (state != ST_IDLE) || flush_pend;

endmodule

// File: tb/tb_iob_cache_replace_ctrl.sv
// tb/tb_iob_cache_replace_ctrl.sv - directed self-checking bench for iob_cache_replace_ctrl
module tb_iob_cache_replace_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  iob_cache_replace_ctrl_if #(.N_WAYS(8), .NLINES_W(3)) bus ();

  iob_cache_replace_ctrl #(.N_WAYS(8), .NLINES_W(3)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic [2:0] line, input logic hit, input logic [7:0] way_hit,
                     input logic [7:0] vways, input logic [7:0] sel);
    bus.req_valid_i      = 1'b1;
    bus.req_line_i       = line;
    bus.req_hit_i        = hit;
    bus.req_way_hit_i    = way_hit;
    bus.req_valid_ways_i = vways;
    bus.rep_way_select_i = sel;
  endtask

  initial begin
    bus.req_valid_i      = 1'b0;
    bus.req_line_i       = '0;
    bus.req_hit_i        = 1'b0;
    bus.req_way_hit_i    = '0;
    bus.req_valid_ways_i = '0;
    bus.flush_i          = 1'b0;
    bus.rep_way_select_i = '0;
    bus.fill_ack_i       = 1'b0;

    tick(); tick();
    chk("rst_ready", bus.req_ready_o, 1);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_fill_req", bus.fill_req_o, 0);
    chk("rst_rep_we", bus.rep_we_o, 0);
    chk("rst_rep_line", bus.rep_line_o, 0);
    chk("rst_done", bus.done_o, 0);
    rst_n = 1'b1;
    tick();

    // 1: hit line 5 way 2
    req(3'd5, 1'b1, 8'h04, 8'hFF, 8'h00);
    tick();
    bus.req_valid_i = 1'b0;
    chk("hit_rep_we", bus.rep_we_o, 1);
    chk("hit_rep_line", bus.rep_line_o, 5);
    chk("hit_rep_way", bus.rep_way_hit_o, 8'h04);
    chk("hit_done", bus.done_o, 1);
    chk("hit_done_way", bus.done_way_o, 8'h04);
    chk("hit_ready_upd", bus.req_ready_o, 0);
    tick();
    chk("hit_ready_after", bus.req_ready_o, 1);
    chk("hit_we_after", bus.rep_we_o, 0);
    chk("hit_line_hold", bus.rep_line_o, 5);
    chk("hit_done_after", bus.done_o, 0);

    // 2: miss, invalid way 2 beats policy select
    req(3'd3, 1'b0, 8'h00, 8'hFB, 8'h80);
    tick();
    bus.req_valid_i = 1'b0;
    chk("vic_we", bus.rep_we_o, 0);
    chk("vic_way_hit", bus.rep_way_hit_o, 0);
    chk("vic_line", bus.rep_line_o, 3);
    chk("vic_busy", bus.busy_o, 1);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("m2_fill_req", bus.fill_req_o, 1);
      chk("m2_fill_way", bus.fill_way_o, 8'h04);
      chk("m2_fill_line", bus.fill_line_o, 3);
      if (i == 3) bus.fill_ack_i = 1'b1;
      tick();
    end
    bus.fill_ack_i = 1'b0;
    chk("m2_fill_req_off", bus.fill_req_o, 0);
    chk("m2_rep_we", bus.rep_we_o, 1);
    chk("m2_rep_way", bus.rep_way_hit_o, 8'h04);
    chk("m2_done_way", bus.done_way_o, 8'h04);
    tick();

    // 3a: all valid, one-hot policy select, held stable despite select change
    req(3'd6, 1'b0, 8'h00, 8'hFF, 8'h10);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    chk("m3a_fill_way", bus.fill_way_o, 8'h10);
    bus.rep_way_select_i = 8'h01;
    tick();
    chk("m3a_fill_way_hold", bus.fill_way_o, 8'h10);
    bus.fill_ack_i = 1'b1;
    tick();
    bus.fill_ack_i = 1'b0;
    chk("m3a_rep_way", bus.rep_way_hit_o, 8'h10);
    chk("m3a_rep_line", bus.rep_line_o, 6);
    tick();

    // 3b: zero select maps to way 0
    req(3'd1, 1'b0, 8'h00, 8'hFF, 8'h00);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    chk("m3b_fill_way", bus.fill_way_o, 8'h01);
    bus.fill_ack_i = 1'b1;
    tick();
    bus.fill_ack_i = 1'b0;
    chk("m3b_done_way", bus.done_way_o, 8'h01);
    tick();

    // 3c: multi-hot select collapses to lowest bit
    req(3'd2, 1'b0, 8'h00, 8'hFF, 8'h28);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    chk("m3c_fill_way", bus.fill_way_o, 8'h08);
    bus.fill_ack_i = 1'b1;
    tick();
    bus.fill_ack_i = 1'b0;
    tick();

    // 4: flush beats a simultaneous request; 8-line sweep then policy reset
    bus.flush_i = 1'b1;
    req(3'd7, 1'b1, 8'h02, 8'hFF, 8'h00);
    #1;
    chk("fl_ready_low", bus.req_ready_o, 0);
    tick();
    bus.flush_i = 1'b0;
    bus.req_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("fl_clr_we", bus.vld_clr_we_o, 1);
      chk("fl_clr_line", bus.vld_clr_line_o, i);
      chk("fl_rep_we", bus.rep_we_o, 0);
      tick();
    end
    chk("fl_end_rst", bus.rep_rst_o, 1);
    chk("fl_end_clr_we", bus.vld_clr_we_o, 0);
    tick();
    chk("fl_rst_off", bus.rep_rst_o, 0);
    chk("fl_busy_off", bus.busy_o, 0);
    chk("fl_ready", bus.req_ready_o, 1);
    chk("fl_line_unchanged", bus.rep_line_o, 2);

    // 5: flush during fill is deferred, request held off until sweep ends
    req(3'd2, 1'b0, 8'h00, 8'hFE, 8'h00);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    chk("p5_fill_req", bus.fill_req_o, 1);
    chk("p5_busy", bus.busy_o, 1);
    bus.fill_ack_i = 1'b1;
    tick();
    bus.fill_ack_i = 1'b0;
    chk("p5_done", bus.done_o, 1);
    chk("p5_rep_way", bus.rep_way_hit_o, 8'h01);
    req(3'd1, 1'b1, 8'h02, 8'hFF, 8'h00);
    tick();
    chk("p5_ready_pend", bus.req_ready_o, 0);
    chk("p5_busy_pend", bus.busy_o, 1);
    chk("p5_no_accept", bus.done_o, 0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("p5_clr_line", bus.vld_clr_line_o, i);
      chk("p5_clr_we", bus.vld_clr_we_o, 1);
      tick();
    end
    chk("p5_rep_rst", bus.rep_rst_o, 1);
    tick();
    chk("p5_ready_after", bus.req_ready_o, 1);
    tick();
    bus.req_valid_i = 1'b0;
    chk("p5_req_rep_line", bus.rep_line_o, 1);
    chk("p5_req_rep_way", bus.rep_way_hit_o, 8'h02);
    chk("p5_req_done", bus.done_o, 1);
    tick();

    // 6: reset during fill abandons it
    req(3'd4, 1'b0, 8'h00, 8'hFF, 8'h40);
    tick();
    bus.req_valid_i = 1'b0;
    tick();
    chk("r6_fill_req", bus.fill_req_o, 1);
    chk("r6_fill_way", bus.fill_way_o, 8'h40);
    rst_n = 1'b0;
    tick();
    chk("r6_fill_req_off", bus.fill_req_o, 0);
    chk("r6_ready", bus.req_ready_o, 1);
    chk("r6_done", bus.done_o, 0);
    chk("r6_busy", bus.busy_o, 0);
    chk("r6_fill_way_clr", bus.fill_way_o, 0);
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
